inst_mem_responder: RTL and testbench

- Responder end of the instruction-fetch interface.
- Accepts the fetch stage's `inst_addr` request and returns the addressed word on `instruction_i` with `instruction_valid`, after a configurable number of wait states.
- Holds a word-addressed instruction store, preloaded through a side write port by the testbench or boot loader.
- Flags misaligned or out-of-range fetches so the pipeline can trap.

---
 rtl/inst_mem_responder_if.sv | 25 ++
 rtl/inst_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_inst_mem_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/inst_mem_responder_if.sv
// Instruction-fetch bus between the fetch stage (master) and the
// instruction memory responder (slave), plus the side preload port.
interface inst_mem_responder_if #(
  parameter int size = 32
) ();
  logic            req_i;
  logic [size-1:0] inst_addr;
  logic            flush;
  logic [size-1:0] instruction_i;
  logic            instruction_valid;
  logic            fetch_fault_o;
  logic            load_we;
  logic [size-1:0] load_addr;
  logic [size-1:0] load_data;

  modport master (
    output req_i, inst_addr, flush, load_we, load_addr, load_data,
    input  instruction_i, instruction_valid, fetch_fault_o
  );

  modport slave (
    input  req_i, inst_addr, flush, load_we, load_addr, load_data,
    output instruction_i, instruction_valid, fetch_fault_o
  );
endinterface

// File: rtl/inst_mem_responder.sv
// Instruction memory responder: word-addressed store with a preload port,
// answering fetch requests after WAIT_STATES extra cycles. Misaligned or
// out-of-range fetches return NOP_WORD with a fault flag so the pipeline
// can trap.
module inst_mem_responder #(
  parameter int              size        = 32,
  parameter int              DEPTH       = 1024,
  parameter int              WAIT_STATES = 1,
  parameter logic [size-1:0] NOP_WORD    = 32'h00000013
) (
  input logic                clk,
  input logic                reset,
  inst_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  // Parameter sanity: the wait counter is 3 bits, the store must be a power
  // of two, and there must be address bits left above the word index.
  if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait_states
    $error("inst_mem_responder: WAIT_STATES must be in 0..7");
  end
  if ((1 << AW) != DEPTH) begin : g_bad_depth
    $error("inst_mem_responder: DEPTH must be a power of two");
  end
  if (AW + 2 >= size) begin : g_bad_width
    $error("inst_mem_responder: DEPTH too large for the address width");
  end

  localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic            fault;
    logic [size-1:0] word;
  } resp_t;

  logic [size-1:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [size-1:0] lat_q, lat_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            vld_q, vld_d;
  logic            rd_en;
  resp_t           resp_q;

  logic            addr_hit;
  logic            lat_bad;
  logic            load_ok;
  logic            unused_load_lo;

  // The preload port ignores the byte offset bits.
  assign unused_load_lo = ^bus.load_addr[1:0];

  // Combinational compare so a PC redirect hides a stale word immediately.
  assign addr_hit = (bus.inst_addr == lat_q);

  // Latched fetch is faulty if misaligned or past the end of the store.
  assign lat_bad  = (|lat_q[1:0]) || (|lat_q[size-1:AW+2]);
  assign load_ok  = ~(|bus.load_addr[size-1:AW+2]);

  assign bus.instruction_i     = resp_q.word;
  assign bus.instruction_valid = vld_q & addr_hit;
  assign bus.fetch_fault_o     = vld_q & addr_hit & resp_q.fault;

  // Preload write; read-before-write falls out of the nonblocking update.
  always_ff @(posedge clk) begin
    if (bus.load_we && load_ok) begin
      mem[bus.load_addr[AW+1:2]] <= bus.load_data;
    end
  end

  // State register for the request FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state logic: flush wins, then per-state handshake rules.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    rd_en   = 1'b0;
    if (bus.flush) begin
      vld_d = 1'b0;
      if (bus.req_i) begin
        // A request alongside flush starts a fresh fetch with full latency.
        state_d = S_WAIT;
        lat_d   = bus.inst_addr;
        cnt_d   = WS_LOAD;
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_i) begin
            state_d = S_WAIT;
            lat_d   = bus.inst_addr;
            cnt_d   = WS_LOAD;
            vld_d   = 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.req_i && !addr_hit) begin
            // Redirect while waiting: drop the old fetch, restart the count.
            lat_d = bus.inst_addr;
            cnt_d = WS_LOAD;
          end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
          end else begin
            state_d = S_RESP;
            vld_d   = 1'b1;
            rd_en   = 1'b1;
          end
        end
        S_RESP: begin
          if (!bus.req_i) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
          end else if (!addr_hit) begin
            state_d = S_WAIT;
            lat_d   = bus.inst_addr;
            cnt_d   = WS_LOAD;
            vld_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
        end
      endcase
    end
  end

  // Response word register; held through stalls, NOP after reset or flush.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      resp_q.fault <= 1'b0;
      resp_q.word  <= NOP_WORD;
    end else if (rd_en) begin
      resp_q.fault <= lat_bad;
      resp_q.word  <= lat_bad ? NOP_WORD : mem[lat_q[AW+1:2]];
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: a per-cycle vector table on a
// WAIT_STATES=1 instance, plus a redirect sequence on a WAIT_STATES=3 one.
module tb_inst_mem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, req, flush, lwe;
  logic [31:0] addr, laddr, ldata;

  always #5 clk = ~clk;

  inst_mem_responder_if #(.size(32)) bus1 ();
  inst_mem_responder_if #(.size(32)) bus3 ();

  assign bus1.req_i = req;   assign bus3.req_i = req;
  assign bus1.inst_addr = addr;  assign bus3.inst_addr = addr;
  assign bus1.flush = flush; assign bus3.flush = flush;
  assign bus1.load_we = lwe; assign bus3.load_we = lwe;
  assign bus1.load_addr = laddr; assign bus3.load_addr = laddr;
  assign bus1.load_data = ldata; assign bus3.load_data = ldata;

  inst_mem_responder #(.size(32), .DEPTH(1024), .WAIT_STATES(1), .NOP_WORD(NOP))
    dut1 (.clk(clk), .reset(rst), .bus(bus1));
  inst_mem_responder #(.size(32), .DEPTH(1024), .WAIT_STATES(3), .NOP_WORD(NOP))
    dut3 (.clk(clk), .reset(rst), .bus(bus3));

  typedef struct {
    logic        rst, req, flush, lwe;
    logic [31:0] addr, laddr, ldata;
    logic        ev, ef, cw;
    logic [31:0] ew;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic [31:0] a, input logic ev,
                              input logic cw, input logic [31:0] ew, input logic ef);
    vec_t v;
    v.rst = 1'b0; v.req = r; v.flush = 1'b0; v.lwe = 1'b0;
    v.addr = a; v.laddr = '0; v.ldata = '0;
    v.ev = ev; v.ef = ef; v.cw = cw; v.ew = ew;
    return v;
  endfunction

  task automatic add(input logic r, input logic [31:0] a, input logic ev,
                     input logic cw, input logic [31:0] ew, input logic ef);
    tbl.push_back(mk(r, a, ev, cw, ew, ef));
  endtask

  task automatic rep(input int n, input logic [31:0] a);
    for (int k = 0; k < n; k++) tbl.push_back(mk(1'b1, a, 1'b0, 1'b0, '0, 1'b0));
  endtask

  task automatic ld(input logic [31:0] la, input logic [31:0] ld_d);
    tbl[tbl.size()-1].lwe   = 1'b1;
    tbl[tbl.size()-1].laddr = la;
    tbl[tbl.size()-1].ldata = ld_d;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int sel, input string tag);
    logic        av, af;
    logic [31:0] aw;
    @(negedge clk);
    rst = v.rst; req = v.req; flush = v.flush; lwe = v.lwe;
    addr = v.addr; laddr = v.laddr; ldata = v.ldata;
    #1;
    if (sel == 0) begin
      av = bus1.instruction_valid; af = bus1.fetch_fault_o; aw = bus1.instruction_i;
    end else begin
      av = bus3.instruction_valid; af = bus3.fetch_fault_o; aw = bus3.instruction_i;
    end
    cmp({tag, ".valid"}, {31'd0, av}, {31'd0, v.ev});
    cmp({tag, ".fault"}, {31'd0, af}, {31'd0, v.ef});
    if (v.cw) cmp({tag, ".word"}, aw, v.ew);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; flush = 1'b0; lwe = 1'b0;
    addr = '0; laddr = '0; ldata = '0;

    // Preload while checking reset outputs.
    add(0, 0, 0, 1, NOP, 0); ld(32'h0, 32'h00500093);
    add(0, 0, 0, 1, NOP, 0); ld(32'h4, 32'h00A00113);
    add(0, 0, 0, 1, NOP, 0); ld(32'h8, 32'h002081B3);
    add(0, 0, 0, 1, NOP, 0); ld(32'hC, 32'h00000013);
    // First fetch: sample, one wait state, read, then valid.
    add(1, 0, 0, 1, NOP, 0); rep(2, 32'h0);
    add(1, 0, 1, 1, 32'h00500093, 0);
    // Step to 0x4.
    rep(3, 32'h4); add(1, 32'h4, 1, 1, 32'h00A00113, 0);
    // 0x8 held for 5 cycles after the response.
    rep(3, 32'h8);
    for (int k = 0; k < 5; k++) add(1, 32'h8, 1, 1, 32'h002081B3, 0);
    // Redirect to 0xC: valid drops in the same cycle.
    rep(3, 32'hC); add(1, 32'hC, 1, 1, 32'h00000013, 0);
    // Misaligned and out-of-range fetches, then a clean one.
    rep(3, 32'h2);        add(1, 32'h2, 1, 1, NOP, 1);
    rep(3, 32'h00001000); add(1, 32'h00001000, 1, 1, NOP, 1);
    rep(3, 32'h4);        add(1, 32'h4, 1, 1, 32'h00A00113, 0);
    // Drop to idle, start 0x4, flush during wait.
    add(0, 32'h4, 1, 1, 32'h00A00113, 0);
    add(0, 32'h4, 0, 0, '0, 0);
    add(1, 32'h4, 0, 0, '0, 0);
    add(0, 32'h4, 0, 0, '0, 0); tbl[tbl.size()-1].flush = 1'b1;
    add(0, 32'h4, 0, 1, NOP, 0);
    rep(3, 32'h4); add(1, 32'h4, 1, 1, 32'h00A00113, 0);
    // Reset while responding.
    add(1, 32'h4, 1, 1, 32'h00A00113, 0); tbl[tbl.size()-1].rst = 1'b1;
    add(0, 32'h4, 0, 1, NOP, 0);
    // Write in the response-read cycle returns old data.
    rep(2, 32'h0);
    rep(1, 32'h0); ld(32'h0, 32'hDEADBEEF);
    add(1, 32'h0, 1, 1, 32'h00500093, 0);
    add(0, 32'h0, 1, 1, 32'h00500093, 0);
    rep(3, 32'h0); add(1, 32'h0, 1, 1, 32'hDEADBEEF, 0);
    // Write during wait is visible; out-of-range write is ignored.
    rep(1, 32'hC);
    rep(1, 32'hC); ld(32'hC, 32'h12345678);
    rep(1, 32'hC);
    add(1, 32'hC, 1, 1, 32'h12345678, 0);
    add(1, 32'hC, 1, 1, 32'h12345678, 0); ld(32'h00001004, 32'hBAD0BAD0);
    rep(3, 32'h4); add(1, 32'h4, 1, 1, 32'h00A00113, 0);

    repeat (2) @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 0, $sformatf("t%0d", i));

    // WAIT_STATES=3: request 0x0, redirect to 0x8 one cycle later.
    @(negedge clk);
    rst = 1'b1; req = 1'b0; flush = 1'b0; lwe = 1'b0;
    step(mk(1, 32'h0, 0, 1, NOP, 0), 1, "ws3_req0");
    step(mk(1, 32'h8, 0, 0, '0, 0), 1, "ws3_redir");
    for (int k = 0; k < 4; k++) step(mk(1, 32'h8, 0, 0, '0, 0), 1, $sformatf("ws3_wait%0d", k));
    step(mk(1, 32'h8, 1, 1, 32'h002081B3, 0), 1, "ws3_resp");

    @(negedge clk);
    req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
